// File: rtl/alu_arb_112_if.sv
// Bundle of request, shared-ALU and response signals for alu_arb_112.
// slave is the arbiter side; master is the requester/ALU side.
interface alu_arb_112_if #(
   parameter int WITDH = 32,
   parameter int CNTW  = 16
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [2:0]       req_op0, req_op1;
   logic [WITDH-1:0] req_a0, req_a1, req_b0, req_b1;
   logic             req_ci0, req_ci1;
   logic [2:0]       alu_op;
   logic [WITDH-1:0] alu_a, alu_b;
   logic             alu_ci;
   logic [WITDH-1:0] alu_result;
   logic             alu_co;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [WITDH-1:0] resp_result;
   logic             resp_co;
   logic             resp_err;
   logic [CNTW-1:0]  op_cnt;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
             req_ci0, req_ci1, alu_result, alu_co, resp_ready,
      output req_ready, alu_op, alu_a, alu_b, alu_ci, resp_valid,
             resp_result, resp_co, resp_err, op_cnt
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
             req_ci0, req_ci1, alu_result, alu_co, resp_ready,
      input  req_ready, alu_op, alu_a, alu_b, alu_ci, resp_valid,
             resp_result, resp_co, resp_err, op_cnt
   );
endinterface

// File: rtl/alu_arb_112.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One op in flight at a time: accept -> EXEC (capture ALU) -> RESP (hold until taken).
module alu_arb_112 #(
   parameter int WITDH = 32,
   parameter int CNTW  = 16
) (
   input logic          clk,
   input logic          rst_n,
   alu_arb_112_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   typedef struct packed {
      logic [2:0]       op;
      logic [WITDH-1:0] a;
      logic [WITDH-1:0] b;
      logic             ci;
   } req_t;

   state_t           state, nxt;
   req_t [1:0]       req_v;
   req_t             cur;
   logic             rr, owner, g, accept, hs;
   logic [1:0]       rdy, rv;
   logic [WITDH-1:0] res_q;
   logic             co_q, err_q;
   logic [CNTW-1:0]  cnt_q;

   assign req_v[0] = {bus.req_op0, bus.req_a0, bus.req_b0, bus.req_ci0};
   assign req_v[1] = {bus.req_op1, bus.req_a1, bus.req_b1, bus.req_ci1};

   // rr only breaks ties; a lone requester always wins.
   assign g = (&bus.req_valid) ? rr : ~bus.req_valid[0];

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      hs     = 1'b0;
      rdy    = '0;
      rv     = '0;
      case (state)
         IDLE: begin
            if (rst_n && (|bus.req_valid)) begin
               accept = 1'b1;
               rdy[g] = 1'b1;
               nxt    = EXEC;
            end
         end
         EXEC: nxt = RESP;
         RESP: begin
            rv[owner] = 1'b1;
            if (bus.resp_ready[owner]) begin
               hs  = 1'b1;
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur   <= '0;
         owner <= 1'b0;
         rr    <= 1'b0;
         res_q <= '0;
         co_q  <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (accept) begin
            cur   <= req_v[g];
            owner <= g;
         end
         // Unsupported opcode reports an error with a zeroed result.
         if (state == EXEC) begin
            if (cur.op == 3'b111) begin
               res_q <= '0;
               co_q  <= 1'b0;
               err_q <= 1'b1;
            end else begin
               res_q <= bus.alu_result;
               co_q  <= bus.alu_co;
               err_q <= 1'b0;
            end
         end
         if (hs) begin
            rr    <= ~owner;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.req_ready   = rdy;
   assign bus.resp_valid  = rv;
   assign bus.alu_op      = cur.op;
   assign bus.alu_a       = cur.a;
   assign bus.alu_b       = cur.b;
   assign bus.alu_ci      = cur.ci;
   assign bus.resp_result = res_q;
   assign bus.resp_co     = co_q;
   assign bus.resp_err    = err_q;
   assign bus.op_cnt      = cnt_q;
endmodule

// File: tb/tb_alu_arb_112.sv
// Bench for alu_arb_112: bench-side ALU, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_arb_112;
   localparam int W    = 32;
   localparam int CW   = 4;
   localparam int MAXC = 1 << CW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arb_112_if #(.WITDH(W), .CNTW(CW)) bus();
   alu_arb_112 #(.WITDH(W), .CNTW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [W:0] alu_ref(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ci);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         3'd2:    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
         3'd3:    return {1'b0, a & b};
         3'd4:    return {1'b0, a | b};
         3'd5:    return {1'b0, a ^ b};
         3'd6:    return {a, 1'b0};
         default: return {1'b1, ~(a ^ b)};
      endcase
   endfunction

   assign {bus.alu_co, bus.alu_result} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_ci);

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding op, response due two cycles after accept.
   logic         m_busy = 1'b0, m_owner = 1'b0, m_rr = 1'b0;
   logic [2:0]   m_op;
   logic [W-1:0] m_a, m_b, m_res;
   logic         m_ci, m_co, m_err;
   int           m_cnt = 0, cyc = 0, acc_cyc = 0, n_hs = 0;
   int           n_acc [2] = '{0, 0};
   logic         gnt_log[$];
   logic         sv_own[$];
   logic [W-1:0] sv_res[$];
   logic         sv_co[$];
   logic         sv_err[$];

   always @(negedge clk) begin
      logic [1:0] er, ev;
      logic       gg;
      cyc++;
      if (!rst_n) begin
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_resp_valid", bus.resp_valid, 0);
         chk("rst_op_cnt", bus.op_cnt, 0);
         chk("rst_resp_result", bus.resp_result, 0);
         chk("rst_resp_co_err", {bus.resp_co, bus.resp_err}, 0);
         chk("rst_alu_regs", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_ci}, 0);
         m_busy = 1'b0;
         m_rr   = 1'b0;
         m_cnt  = 0;
      end else begin
         er = '0;
         gg = (bus.req_valid == 2'b11) ? m_rr : (bus.req_valid[0] ? 1'b0 : 1'b1);
         if (!m_busy && bus.req_valid != 2'b00) er[gg] = 1'b1;
         ev = (m_busy && cyc >= acc_cyc + 2) ? (2'b01 << m_owner) : 2'b00;
         chk("req_ready", bus.req_ready, er);
         chk("resp_valid", bus.resp_valid, ev);
         chk("op_cnt", bus.op_cnt, m_cnt);
         if (m_busy && cyc > acc_cyc)
            chk("alu_drive", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_ci}, {m_op, m_a, m_b, m_ci});
         if (ev != 2'b00) begin
            chk("resp_result", bus.resp_result, m_res);
            chk("resp_co_err", {bus.resp_co, bus.resp_err}, {m_co, m_err});
         end
         if (er != 2'b00) begin
            m_busy  = 1'b1;
            acc_cyc = cyc;
            m_owner = gg;
            m_op = gg ? bus.req_op1 : bus.req_op0;
            m_a  = gg ? bus.req_a1  : bus.req_a0;
            m_b  = gg ? bus.req_b1  : bus.req_b0;
            m_ci = gg ? bus.req_ci1 : bus.req_ci0;
            if (m_op == 3'b111) begin
               m_res = '0; m_co = 1'b0; m_err = 1'b1;
            end else begin
               {m_co, m_res} = alu_ref(m_op, m_a, m_b, m_ci);
               m_err = 1'b0;
            end
            n_acc[gg]++;
            gnt_log.push_back(gg);
         end else if (ev != 2'b00 && bus.resp_ready[m_owner]) begin
            sv_own.push_back(m_owner);
            sv_res.push_back(bus.resp_result);
            sv_co.push_back(bus.resp_co);
            sv_err.push_back(bus.resp_err);
            m_busy = 1'b0;
            m_rr   = ~m_owner;
            m_cnt  = (m_cnt + 1) % MAXC;
            n_hs++;
         end
      end
   end

   // Stimulus side
   logic keep [2] = '{1'b0, 1'b0};
   int   seen_acc [2] = '{0, 0};
   bit   rand_mode = 1'b0;

   task automatic set_req(int r, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ci);
      if (r == 0) begin
         bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_ci0 = ci;
      end else begin
         bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_ci1 = ci;
      end
   endtask

   task automatic rnd_req(int r);
      logic [2:0] op;
      op = ($urandom_range(7) == 0) ? 3'd7 : 3'($urandom_range(6));
      set_req(r, op, $urandom, $urandom, 1'($urandom_range(1)));
   endtask

   task automatic tick();
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         if (n_acc[r] != seen_acc[r]) begin
            seen_acc[r] = n_acc[r];
            if (keep[r]) rnd_req(r);
            else         bus.req_valid[r] = 1'b0;
         end
      end
      if (rand_mode) begin
         for (int r = 0; r < 2; r++) begin
            if (!bus.req_valid[r]) begin
               if ($urandom_range(3) == 0) begin
                  rnd_req(r);
                  bus.req_valid[r] = 1'b1;
               end
            end else if ($urandom_range(15) == 0) begin
               bus.req_valid[r] = 1'b0;
            end
         end
         bus.resp_ready = 2'($urandom_range(3));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      keep[0] = 1'b0; keep[1] = 1'b0;
      seen_acc[0] = n_acc[0]; seen_acc[1] = n_acc[1];
   endtask

   task automatic wait_hs(int target, int budget, string nm);
      int k = 0;
      while (n_hs < target && k < budget) begin
         tick();
         k++;
      end
      chk(nm, (n_hs >= target), 1);
   endtask

   initial begin
      int h0, b0, g0;
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b11;
      set_req(0, 3'd0, '0, '0, 1'b0);
      set_req(1, 3'd0, '0, '0, 1'b0);
      do_reset();

      // Single add from requester 0
      h0 = n_hs; b0 = sv_res.size();
      set_req(0, 3'd0, 456, 234, 1'b0);
      bus.req_valid = 2'b01;
      wait_hs(h0 + 1, 20, "t_add_timeout");
      chk("t_add_owner", sv_own[b0], 0);
      chk("t_add_result", sv_res[b0], 690);
      chk("t_add_cnt", bus.op_cnt, 1);

      // Simultaneous requests after reset: requester 0 first
      do_reset();
      h0 = n_hs; b0 = sv_res.size();
      set_req(0, 3'd1, 456, 234, 1'b1);
      set_req(1, 3'd2, 245, 678, 1'b1);
      bus.req_valid = 2'b11;
      wait_hs(h0 + 2, 30, "t_both_timeout");
      chk("t_both_first_owner", sv_own[b0], 0);
      chk("t_both_first_result", sv_res[b0], 691);
      chk("t_both_second_owner", sv_own[b0 + 1], 1);
      chk("t_both_second_result", sv_res[b0 + 1], 32'hFFFF_FE4E);
      chk("t_both_second_borrow", sv_co[b0 + 1], 1);
      chk("t_both_cnt", bus.op_cnt, 2);

      // Continuous contention alternates grants
      h0 = n_hs; g0 = gnt_log.size();
      rnd_req(0); rnd_req(1);
      keep[0] = 1'b1; keep[1] = 1'b1;
      bus.req_valid = 2'b11;
      wait_hs(h0 + 6, 40, "t_alt_timeout");
      bus.req_valid = 2'b00;
      keep[0] = 1'b0; keep[1] = 1'b0;
      for (int i = 0; i < 6; i++) chk("t_alt_grant", gnt_log[g0 + i], i % 2);

      // Unsupported opcode, then a legal op clears the error
      h0 = n_hs; b0 = sv_res.size();
      set_req(1, 3'd7, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
      bus.req_valid = 2'b10;
      wait_hs(h0 + 1, 20, "t_err_timeout");
      chk("t_err_flag", sv_err[b0], 1);
      chk("t_err_result", sv_res[b0], 0);
      chk("t_err_co", sv_co[b0], 0);
      set_req(1, 3'd3, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
      bus.req_valid = 2'b10;
      wait_hs(h0 + 2, 20, "t_err_clr_timeout");
      chk("t_err_cleared", sv_err[b0 + 1], 0);
      chk("t_err_clr_result", sv_res[b0 + 1], 32'h0000_F000);

      // Stalled response stays stable, then reset abandons it
      set_req(0, 3'd0, 100, 23, 1'b0);
      bus.req_valid = 2'b01;
      bus.resp_ready = 2'b00;
      tick(); tick();
      set_req(1, 3'd4, 5, 10, 1'b0);
      bus.req_valid = 2'b10;
      repeat (5) tick();
      chk("t_stall_valid", bus.resp_valid, 2'b01);
      chk("t_stall_result", bus.resp_result, 123);
      chk("t_stall_ready", bus.req_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("t_rst_resp_valid", bus.resp_valid, 0);
      chk("t_rst_cnt", bus.op_cnt, 0);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b11;
      rst_n = 1'b1;
      seen_acc[0] = n_acc[0]; seen_acc[1] = n_acc[1];
      repeat (3) tick();

      // Counter wrap at 2^CW completions
      do_reset();
      h0 = n_hs;
      rnd_req(0);
      keep[0] = 1'b1;
      bus.req_valid = 2'b01;
      wait_hs(h0 + MAXC - 1, 100, "t_wrap_pre_timeout");
      bus.req_valid = 2'b00;
      keep[0] = 1'b0;
      chk("t_wrap_allones", bus.op_cnt, MAXC - 1);
      set_req(0, 3'd5, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
      bus.req_valid = 2'b01;
      wait_hs(h0 + MAXC, 20, "t_wrap_timeout");
      chk("t_wrap_zero", bus.op_cnt, 0);

      // Random traffic with withdrawals and response back-pressure
      rand_mode = 1'b1;
      repeat (500) tick();
      rand_mode = 1'b0;
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b11;
      repeat (8) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before t=1000000");
      $fatal(1, "watchdog expired");
   end
endmodule
